// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants, helpers, state enum and color-bar table for vga_timing_gen
package vga_pkg;

  // Default raster timing for 640x480@60 at a 25.175 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  // Color bars left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [0:7][23:0] BAR_COLORS = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_lock_qualifier.sv
// rtl/vga_timing_gen_lock_qualifier.sv - PLL lock synchronizer and stability qualifier (module lock_qualifier)
module lock_qualifier #(
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  output logic lock_s,
  output logic qualified
);

  // Counter only needs to reach LOCK_CYCLES-1 and then saturates
  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_CYCLES - 1);

  logic          meta;
  logic [CW-1:0] lock_cnt;

  // Two-flop synchronizer for the asynchronous lock indicator
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      meta   <= locked;
      lock_s <= meta;
    end
  end

  // Count consecutive synchronized-lock cycles; any drop restarts the count
  always_ff @(posedge clk) begin
    if (rst || !lock_s) begin
      lock_cnt <= '0;
    end else if (lock_cnt != CNT_LAST) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // Qualified once the count has reached its last value with lock still present
  always_ff @(posedge clk) begin
    if (rst) begin
      qualified <= 1'b0;
    end else begin
      qualified <= lock_s && (lock_cnt == CNT_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; optional color bars on rgb when VGA_TEST_PATTERN_EN is defined
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [23:0] rgb
`endif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  state_t        state;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          lock_s;
  logic          qualified;

  lock_qualifier #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_qualifier (
    .clk      (clk),
    .rst      (rst),
    .locked   (locked),
    .lock_s   (lock_s),
    .qualified(qualified)
  );

  // Raster state machine: waits for a qualified lock, then scans h/v until lock is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_LOCK;
      running <= 1'b0;
      h       <= '0;
      v       <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          h <= '0;
          v <= '0;
          if (qualified && lock_s) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state   <= WAIT_LOCK;
            running <= 1'b0;
            h       <= '0;
            v       <= '0;
          end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
          end else begin
            h <= h + 1'b1;
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          running <= 1'b0;
          h       <= '0;
          v       <= '0;
        end
      endcase
    end
  end

  // Combinational decode of the current raster position
  logic [31:0] h_ext;
  logic [31:0] v_ext;
  logic        de_c;
  logic        hs_c;
  logic        vs_c;

  assign h_ext = 32'(h);
  assign v_ext = 32'(v);
  assign de_c  = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
  assign hs_c  = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_c  = (v_ext >= VS_START) && (v_ext < VS_END);

  // Registered outputs; forced idle outside RUN and on the same edge that lock is lost
  always_ff @(posedge clk) begin
    if (rst || (state != RUN) || !lock_s) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_c ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_c ? SYNC_POL : ~SYNC_POL;
      de          <= de_c;
      x           <= de_c ? 10'(h) : 10'd0;
      y           <= de_c ? 10'(v) : 10'd0;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar_idx;
  assign bar_idx = 3'(h_ext / BAR_W);

  // Color-bar pixel, aligned with de
  always_ff @(posedge clk) begin
    if (rst || (state != RUN) || !lock_s || !de_c) begin
      rgb <= '0;
    end else begin
      rgb <= BAR_COLORS[bar_idx];
    end
  end
`endif

endmodule
